// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. It sends one command byte (for example
// 0xED set-LEDs or 0xFF reset) to the keyboard over the open-drain PS/2 lines.
// The lines are driven only through output enables: OE=1 pulls a line low.
// The scan-code receiver on the same pins ignores the bus while oBusy=1.
//
// Sequence: the host inhibits (holds CLK low) for INHIBIT_CYCLES, places the
// start bit and releases CLK. The device then clocks out data LSB first, odd
// parity and stop. The host samples the device ACK on the 11th falling edge
// and waits for both lines to go idle before it reports oDone.
//
// Parameters:
//   INHIBIT_CYCLES  cycles PS2_CLK is held low before the start bit
//   TIMEOUT_CYCLES  watchdog limit from CLK release (PS2_TX_TIMEOUT_EN only)
//
// Ports:
//   Clock         system clock, all state on posedge
//   Reset         asynchronous, active-high
//   iData[7:0]    command byte, captured when iSend is accepted
//   iSend         transmit request, accepted only when idle
//   iPS2_CLK      raw PS/2 clock pin level (asynchronous)
//   iPS2_DATA     raw PS/2 data pin level (asynchronous)
//   oPS2_CLK_OE   1 = pull PS2_CLK low
//   oPS2_DATA_OE  1 = pull PS2_DATA low
//   oBusy         high from acceptance until the return to idle
//   oDone         one-cycle pulse: byte sent and ACK received
//   oError        one-cycle pulse: ACK missing or watchdog expired
//
// Build option:
//   PS2_TX_TIMEOUT_EN  when defined, a 20-bit watchdog aborts a transfer the
//                      device never completes. When undefined the FSM waits
//                      for the device indefinitely.
// ----------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iSend,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DATA,
    output logic       oPS2_CLK_OE,
    output logic       oPS2_DATA_OE,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError
);

    localparam int            IW       = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SEND,
        S_ACK,
        S_WAITHI,
        S_ERR
    } state_t;

    state_t        state_q;
    logic [10:0]   frame_q;
    logic [IW-1:0] inh_cnt_q;
    logic [3:0]    edge_cnt_q;
    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          data_s1_q, data_s2_q;
    logic          clk_oe_q, data_oe_q, busy_q, done_q, err_q;
    logic          clk_fall;

`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYCLES - 1);
    logic [19:0] wd_q;
    logic        wd_hit;

    // The watchdog only matters once the device owns the clock.
    assign wd_hit = ((state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAITHI))
                    && (wd_q == WD_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // Falling edge on the synchronized clock (previous 1, current 0).
    assign clk_fall = clk_prev_q & ~clk_s2_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            frame_q    <= '0;
            inh_cnt_q  <= '0;
            edge_cnt_q <= '0;
            // Synchronizers start at the idle bus level so reset release
            // cannot be mistaken for a falling edge.
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            clk_s1_q   <= iPS2_CLK;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= iPS2_DATA;
            data_s2_q  <= data_s1_q;
            done_q     <= 1'b0;
            err_q      <= 1'b0;

`ifdef PS2_TX_TIMEOUT_EN
            if (state_q == S_IDLE) begin
                wd_q <= '0;
            end else if ((state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAITHI)) begin
                wd_q <= wd_q + 20'd1;
            end

            if (wd_hit) begin
                clk_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
                state_q   <= S_ERR;
            end else
`endif
            case (state_q)
                S_IDLE: begin
                    inh_cnt_q  <= '0;
                    edge_cnt_q <= '0;
                    if (iSend) begin
                        frame_q  <= {1'b1, ~^iData, iData, 1'b0};
                        busy_q   <= 1'b1;
                        clk_oe_q <= 1'b1;
                        state_q  <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt_q == INH_LAST) begin
                        // Start bit goes out on the same edge that frees CLK.
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= ~frame_q[0];
                        state_q   <= S_SEND;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + IW'(1);
                    end
                end
                S_SEND: begin
                    if (clk_fall) begin
                        edge_cnt_q <= edge_cnt_q + 4'd1;
                        data_oe_q  <= ~frame_q[1];
                        frame_q    <= {1'b1, frame_q[10:1]};
                        if (edge_cnt_q == 4'd9) begin
                            state_q <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    if (clk_fall) begin
                        edge_cnt_q <= edge_cnt_q + 4'd1;
                        state_q    <= data_s2_q ? S_ERR : S_WAITHI;
                    end
                end
                S_WAITHI: begin
                    if (clk_s2_q && data_s2_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_ERR: begin
                    err_q     <= 1'b1;
                    busy_q    <= 1'b0;
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oPS2_CLK_OE  = clk_oe_q;
    assign oPS2_DATA_OE = data_oe_q;
    assign oBusy        = busy_q;
    assign oDone        = done_q;
    assign oError       = err_q;

endmodule
